// File: rtl/axil_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite register slave.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder for the control/status register bank behind the PCIe-to-AXI bridge.
// state   | meaning
// WR_IDLE | collecting AW and W (either order); write applied on the edge both are held
// WR_RESP | bvalid/bresp presented, waiting for bready
// RD_IDLE | arready high, waiting for AR
// RD_DATA | rvalid/rdata/rresp presented, waiting for rready
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int NREGS  = 16,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                           axi_clk,
    input  logic                           axi_aresetn,
    input  logic [ADDR_W-1:0]              s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_W-1:0]              s_wdata,
    input  logic [DATA_W/8-1:0]            s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_W-1:0]              s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_W-1:0]              s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NREGS-1:0][DATA_W-1:0]   slv_reg,
    input  logic [NREGS-1:0][DATA_W-1:0]   slv_read,
    output logic [NREGS-1:0]               reg_wr_stb,
    output logic [NREGS-1:0]               reg_rd_stb
);

    localparam int IDX_W = $clog2(NREGS);
    // Widened by one bit so a window covering the whole address space still compares correctly.
    localparam logic [ADDR_W:0] WIN = (ADDR_W+1)'(NREGS * 4);

    wr_state_t            wr_state;
    rd_state_t            rd_state;

    logic                 aw_held;
    logic                 w_held;
    logic [ADDR_W-1:0]    aw_addr_lat;
    logic [DATA_W-1:0]    w_data_lat;
    logic [DATA_W/8-1:0]  w_strb_lat;

    logic                 aw_hs;
    logic                 w_hs;
    logic                 ar_hs;
    logic                 aw_have;
    logic                 w_have;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [DATA_W/8-1:0]  wr_strb;
    logic [IDX_W-1:0]     wr_idx;
    logic                 wr_in_range;
    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_in_range;

    // A handshake on this edge takes priority over the latched copy.
    always_comb begin
        aw_hs       = s_awvalid & s_awready;
        w_hs        = s_wvalid & s_wready;
        ar_hs       = s_arvalid & s_arready;
        aw_have     = aw_held | aw_hs;
        w_have      = w_held | w_hs;
        wr_addr     = aw_hs ? s_awaddr : aw_addr_lat;
        wr_data     = w_hs ? s_wdata : w_data_lat;
        wr_strb     = w_hs ? s_wstrb : w_strb_lat;
        wr_idx      = wr_addr[IDX_W+1:2];
        wr_in_range = {1'b0, wr_addr} < WIN;
        rd_idx      = s_araddr[IDX_W+1:2];
        rd_in_range = {1'b0, s_araddr} < WIN;
    end

    always_ff @(posedge axi_clk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_state    <= WR_IDLE;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_addr_lat <= '0;
            w_data_lat  <= '0;
            w_strb_lat  <= '0;
            s_awready   <= 1'b0;
            s_wready    <= 1'b0;
            s_bvalid    <= 1'b0;
            s_bresp     <= RESP_OKAY;
            slv_reg     <= '0;
            reg_wr_stb  <= '0;
        end else begin
            reg_wr_stb <= '0;
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) aw_addr_lat <= s_awaddr;
                    if (w_hs) begin
                        w_data_lat <= s_wdata;
                        w_strb_lat <= s_wstrb;
                    end
                    if (aw_have && w_have) begin
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b0;
                        s_bvalid  <= 1'b1;
                        wr_state  <= WR_RESP;
                        if (wr_in_range) begin
                            for (int b = 0; b < DATA_W/8; b++) begin
                                if (wr_strb[b]) slv_reg[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                            end
                            reg_wr_stb[wr_idx] <= 1'b1;
                            s_bresp            <= RESP_OKAY;
                        end else begin
                            s_bresp <= RESP_DECERR;
                        end
                    end else begin
                        aw_held   <= aw_have;
                        w_held    <= w_have;
                        s_awready <= !aw_have;
                        s_wready  <= !w_have;
                    end
                end
                WR_RESP: begin
                    if (s_bready) begin
                        s_bvalid  <= 1'b0;
                        s_awready <= 1'b1;
                        s_wready  <= 1'b1;
                        wr_state  <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_clk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rd_state   <= RD_IDLE;
            s_arready  <= 1'b0;
            s_rvalid   <= 1'b0;
            s_rdata    <= '0;
            s_rresp    <= RESP_OKAY;
            reg_rd_stb <= '0;
        end else begin
            reg_rd_stb <= '0;
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        s_arready <= 1'b0;
                        s_rvalid  <= 1'b1;
                        rd_state  <= RD_DATA;
                        if (rd_in_range) begin
                            s_rdata            <= slv_read[rd_idx];
                            s_rresp            <= RESP_OKAY;
                            reg_rd_stb[rd_idx] <= 1'b1;
                        end else begin
                            s_rdata <= '0;
                            s_rresp <= RESP_DECERR;
                        end
                    end else begin
                        s_arready <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (s_rready) begin
                        s_rvalid  <= 1'b0;
                        s_arready <= 1'b1;
                        rd_state  <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed self-checking bench for axil_reg_slave: write/read paths, decode errors, backpressure, reset.
module tb_axil_reg_slave;

    logic                axi_clk = 1'b0;
    logic                axi_aresetn;
    logic [7:0]          s_awaddr;
    logic                s_awvalid;
    logic                s_awready;
    logic [31:0]         s_wdata;
    logic [3:0]          s_wstrb;
    logic                s_wvalid;
    logic                s_wready;
    logic [1:0]          s_bresp;
    logic                s_bvalid;
    logic                s_bready;
    logic [7:0]          s_araddr;
    logic                s_arvalid;
    logic                s_arready;
    logic [31:0]         s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rvalid;
    logic                s_rready;
    logic [15:0][31:0]   slv_reg;
    logic [15:0][31:0]   slv_read;
    logic [15:0]         reg_wr_stb;
    logic [15:0]         reg_rd_stb;

    int checks   = 0;
    int failures = 0;

    logic [1:0]          resp;
    logic [15:0]         stb;
    logic [15:0][31:0]   snap;

    axil_reg_slave dut (
        .axi_clk     (axi_clk),
        .axi_aresetn (axi_aresetn),
        .s_awaddr    (s_awaddr),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_bresp     (s_bresp),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .s_araddr    (s_araddr),
        .s_arvalid   (s_arvalid),
        .s_arready   (s_arready),
        .s_rdata     (s_rdata),
        .s_rresp     (s_rresp),
        .s_rvalid    (s_rvalid),
        .s_rready    (s_rready),
        .slv_reg     (slv_reg),
        .slv_read    (slv_read),
        .reg_wr_stb  (reg_wr_stb),
        .reg_rd_stb  (reg_rd_stb)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r, output logic [15:0] st);
        logic ag, wg;
        s_awaddr  = a;
        s_wdata   = d;
        s_wstrb   = s;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        st        = '0;
        for (int i = 0; i < 20 && (s_awvalid || s_wvalid); i++) begin
            ag = s_awready;
            wg = s_wready;
            tick();
            if (ag) s_awvalid = 1'b0;
            if (wg) s_wvalid = 1'b0;
            st |= reg_wr_stb;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        for (int i = 0; i < 20 && !s_bvalid; i++) tick();
        chk("wr_bvalid_seen", {31'b0, s_bvalid}, 32'd1);
        r = s_bresp;
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        axi_aresetn = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        for (int i = 0; i < 16; i++) slv_read[i] = 32'h1000_0000 + i;
        slv_read[0] = 32'hDEADBEEF;
        slv_read[1] = 32'h76543210;

        // Reset state
        repeat (3) tick();
        chk("rst_awready", {31'b0, s_awready}, 32'd0);
        chk("rst_arready", {31'b0, s_arready}, 32'd0);
        chk("rst_bvalid",  {31'b0, s_bvalid}, 32'd0);
        chk("rst_rvalid",  {31'b0, s_rvalid}, 32'd0);
        chk("rst_rdata",   s_rdata, 32'd0);
        chk("rst_slv_reg_any", {31'b0, |slv_reg}, 32'd0);
        axi_aresetn = 1'b1;
        tick();
        chk("rel_awready", {31'b0, s_awready}, 32'd1);
        chk("rel_wready",  {31'b0, s_wready}, 32'd1);
        chk("rel_arready", {31'b0, s_arready}, 32'd1);

        // 1: AW+W same cycle to 0x1C
        s_awaddr = 8'h1C; s_awvalid = 1'b1;
        s_wdata = 32'h0000_00A5; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("t1_slv_reg7", slv_reg[7], 32'h0000_00A5);
        chk("t1_wr_stb",   {16'b0, reg_wr_stb}, 32'h0000_0080);
        chk("t1_bvalid",   {31'b0, s_bvalid}, 32'd1);
        chk("t1_bresp",    {30'b0, s_bresp}, 32'd0);
        chk("t1_awready_low", {31'b0, s_awready}, 32'd0);
        tick();
        chk("t1_wr_stb_pulse", {16'b0, reg_wr_stb}, 32'd0);
        chk("t1_bvalid_held",  {31'b0, s_bvalid}, 32'd1);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        chk("t1_bvalid_clr", {31'b0, s_bvalid}, 32'd0);
        chk("t1_awready_back", {31'b0, s_awready}, 32'd1);
        chk("t1_wready_back",  {31'b0, s_wready}, 32'd1);

        // 2: W first, AW three cycles later, partial strobe over 0xFFFFFFFF
        do_write(8'h08, 32'hFFFF_FFFF, 4'hF, resp, stb);
        chk("t2_preload", slv_reg[2], 32'hFFFF_FFFF);
        s_wdata = 32'h1234_5678; s_wstrb = 4'h3; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        chk("t2_wready_low", {31'b0, s_wready}, 32'd0);
        chk("t2_awready_hi", {31'b0, s_awready}, 32'd1);
        tick();
        tick();
        chk("t2_no_bvalid_yet", {31'b0, s_bvalid}, 32'd0);
        chk("t2_reg_unchanged", slv_reg[2], 32'hFFFF_FFFF);
        s_awaddr = 8'h08; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        chk("t2_slv_reg2", slv_reg[2], 32'hFFFF_5678);
        chk("t2_wr_stb",   {16'b0, reg_wr_stb}, 32'h0000_0004);
        chk("t2_bvalid",   {31'b0, s_bvalid}, 32'd1);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;

        // 3: read 0x04 with rready stalled 5 cycles
        s_araddr = 8'h04; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        chk("t3_rvalid",  {31'b0, s_rvalid}, 32'd1);
        chk("t3_rdata",   s_rdata, 32'h7654_3210);
        chk("t3_rresp",   {30'b0, s_rresp}, 32'd0);
        chk("t3_rd_stb",  {16'b0, reg_rd_stb}, 32'h0000_0002);
        chk("t3_arready_low", {31'b0, s_arready}, 32'd0);
        slv_read[1] = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_rdata_stable", s_rdata, 32'h7654_3210);
            chk("t3_arready_stall", {31'b0, s_arready}, 32'd0);
        end
        chk("t3_rd_stb_pulse", {16'b0, reg_rd_stb}, 32'd0);
        chk("t3_rvalid_stall", {31'b0, s_rvalid}, 32'd1);
        slv_read[1] = 32'h7654_3210;
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        chk("t3_rvalid_clr", {31'b0, s_rvalid}, 32'd0);
        chk("t3_arready_back", {31'b0, s_arready}, 32'd1);

        // 4: out-of-range write 0x40 and read 0x44 together
        snap = slv_reg;
        s_awaddr = 8'h40; s_awvalid = 1'b1;
        s_wdata = 32'h1111_1111; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_araddr = 8'h44; s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        chk("t4_bvalid", {31'b0, s_bvalid}, 32'd1);
        chk("t4_bresp",  {30'b0, s_bresp}, 32'd3);
        chk("t4_wr_stb", {16'b0, reg_wr_stb}, 32'd0);
        chk("t4_rvalid", {31'b0, s_rvalid}, 32'd1);
        chk("t4_rresp",  {30'b0, s_rresp}, 32'd3);
        chk("t4_rdata",  s_rdata, 32'd0);
        chk("t4_rd_stb", {16'b0, reg_rd_stb}, 32'd0);
        chk("t4_no_reg_change", {31'b0, slv_reg === snap}, 32'd1);
        chk("t4_alias_reg0", slv_reg[0], 32'd0);
        s_bready = 1'b1; s_rready = 1'b1;
        tick();
        s_bready = 1'b0; s_rready = 1'b0;

        // 5: back-to-back reads 0x00 then 0x04, rready held high
        s_rready = 1'b1;
        s_araddr = 8'h00; s_arvalid = 1'b1;
        tick();
        chk("t5_rvalid0", {31'b0, s_rvalid}, 32'd1);
        chk("t5_rdata0",  s_rdata, 32'hDEAD_BEEF);
        chk("t5_arready0", {31'b0, s_arready}, 32'd0);
        s_araddr = 8'h04;
        tick();
        chk("t5_gap_rvalid", {31'b0, s_rvalid}, 32'd0);
        chk("t5_gap_arready", {31'b0, s_arready}, 32'd1);
        tick();
        s_arvalid = 1'b0;
        chk("t5_rvalid1", {31'b0, s_rvalid}, 32'd1);
        chk("t5_rdata1",  s_rdata, 32'h7654_3210);
        chk("t5_rd_stb1", {16'b0, reg_rd_stb}, 32'h0000_0002);
        tick();
        chk("t5_done", {31'b0, s_rvalid}, 32'd0);
        s_rready = 1'b0;

        // 6: reset while bvalid pending
        s_awaddr = 8'h0C; s_awvalid = 1'b1;
        s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("t6_bvalid_pending", {31'b0, s_bvalid}, 32'd1);
        chk("t6_reg3", slv_reg[3], 32'hCAFE_F00D);
        #2;
        axi_aresetn = 1'b0;
        #1;
        chk("t6_bvalid_async", {31'b0, s_bvalid}, 32'd0);
        chk("t6_regs_cleared", {31'b0, |slv_reg}, 32'd0);
        chk("t6_awready_rst", {31'b0, s_awready}, 32'd0);
        tick();
        axi_aresetn = 1'b1;
        tick();
        chk("t6_awready_rel", {31'b0, s_awready}, 32'd1);
        do_write(8'h10, 32'h55AA_55AA, 4'b0101, resp, stb);
        chk("t6_clean_reg4", slv_reg[4], 32'h00AA_00AA);
        chk("t6_clean_bresp", {30'b0, resp}, 32'd0);
        chk("t6_clean_stb", {16'b0, stb}, 32'h0000_0010);
        do_write(8'h12, 32'hFFFF_FFFF, 4'b0000, resp, stb);
        chk("t6_zero_strb_reg4", slv_reg[4], 32'h00AA_00AA);
        chk("t6_zero_strb_bresp", {30'b0, resp}, 32'd0);
        chk("t6_zero_strb_stb", {16'b0, stb}, 32'h0000_0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
